pw_trigger_seq: RTL and testbench

//  Multi-pulse trigger sequencer, successor to the single delay/width trigger generator.
//  On a pattern-matcher hit it emits up to pNUM_PULSES trigger pulses on cw_trig/mcx_trig.

---
 rtl/pw_trigger_seq.sv | 191 +++++++++++++++++++
 tb/tb_pw_trigger_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pw_trigger_seq.sv
`default_nettype none
// ============================================================================
// Module      : pw_trigger_seq
// Description : Multi-pulse trigger sequencer. A start strobe from the pattern
//               matcher launches a sequence of up to pNUM_PULSES trigger
//               pulses, each with its own delay and high time. The active
//               configuration is shadowed when the sequence starts.
// Ports       : fe_clk          - clock
//               reset_n         - asynchronous active-low reset
//               I_arm           - enable; low returns to idle (abort)
//               I_match         - 1-cycle start strobe
//               I_num_pulses    - pulses per sequence (0 disables, clamps high)
//               I_delays        - packed per-pulse delays (pulse 0 in LSBs)
//               I_widths        - packed per-pulse high times (pulse 0 in LSBs)
//               O_trigger       - registered trigger output
//               O_trigger_pulse - 1-cycle strobe on each trigger rising edge
//               O_pulse_index   - index of current/next pulse
//               O_busy          - sequence in progress
//               O_done          - 1-cycle strobe when the last pulse falls
// Revision    : 1.0 - initial release
// ============================================================================
module pw_trigger_seq #(
  parameter int pNUM_PULSES  = 4,
  parameter int pDELAY_WIDTH = 20,
  parameter int pWIDTH_WIDTH = 17
) (
  input  logic                                fe_clk,
  input  logic                                reset_n,
  input  logic                                I_arm,
  input  logic                                I_match,
  input  logic [7:0]                          I_num_pulses,
  input  logic [pNUM_PULSES*pDELAY_WIDTH-1:0] I_delays,
  input  logic [pNUM_PULSES*pWIDTH_WIDTH-1:0] I_widths,
  output logic                                O_trigger,
  output logic                                O_trigger_pulse,
  output logic [7:0]                          O_pulse_index,
  output logic                                O_busy,
  output logic                                O_done
);

  localparam int         DW    = pDELAY_WIDTH;
  localparam int         WW    = pWIDTH_WIDTH;
  localparam int         NP    = pNUM_PULSES;
  localparam logic [7:0] MAX_N = 8'(pNUM_PULSES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_HIGH  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         idx_q, idx_d;
  logic [7:0]         last_q, last_d;
  logic [DW-1:0]      dcnt_q, dcnt_d;
  logic [WW-1:0]      wcnt_q, wcnt_d;
  logic [NP*DW-1:0]   dly_q, dly_d;
  logic [NP*WW-1:0]   wid_q, wid_d;
  logic               trig_q, trig_d;
  logic               pulse_q, pulse_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [7:0]         n_clamp;
  logic [7:0]         idx_inc;
  logic [7:0]         idx_nxt;

  // A zero count still has to produce one cycle, so edges stay distinct.
  function automatic logic [WW-1:0] w_at_least_one(input logic [WW-1:0] v);
    return (v == '0) ? WW'(1) : v;
  endfunction

  function automatic logic [DW-1:0] d_at_least_one(input logic [DW-1:0] v);
    return (v == '0) ? DW'(1) : v;
  endfunction

  assign n_clamp = (I_num_pulses > MAX_N) ? MAX_N : I_num_pulses;
  assign idx_inc = idx_q + 8'd1;
  // Keeps the shadow lookup in range; only used when another pulse follows.
  assign idx_nxt = (idx_inc < MAX_N) ? idx_inc : idx_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    dcnt_d  = dcnt_q;
    wcnt_d  = wcnt_q;
    dly_d   = dly_q;
    wid_d   = wid_q;
    trig_d  = trig_q;
    pulse_d = 1'b0;
    done_d  = 1'b0;

    if (!I_arm) begin
      state_d = ST_IDLE;
      idx_d   = 8'd0;
      trig_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // done_q blocks a match coinciding with the end of the last run.
          if (I_match && (I_num_pulses != 8'd0) && !done_q) begin
            dly_d  = I_delays;
            wid_d  = I_widths;
            last_d = n_clamp - 8'd1;
            idx_d  = 8'd0;
            // First delay of zero rises on the very next cycle.
            if (I_delays[DW-1:0] == '0) begin
              state_d = ST_HIGH;
              trig_d  = 1'b1;
              pulse_d = 1'b1;
              wcnt_d  = w_at_least_one(I_widths[WW-1:0]);
            end else begin
              state_d = ST_DELAY;
              dcnt_d  = I_delays[DW-1:0];
            end
          end
        end
        ST_DELAY: begin
          if (dcnt_q <= DW'(1)) begin
            state_d = ST_HIGH;
            trig_d  = 1'b1;
            pulse_d = 1'b1;
            wcnt_d  = w_at_least_one(wid_q[int'(idx_q)*WW +: WW]);
          end else begin
            dcnt_d = dcnt_q - DW'(1);
          end
        end
        ST_HIGH: begin
          if (wcnt_q <= WW'(1)) begin
            trig_d = 1'b0;
            if (idx_q == last_q) begin
              state_d = ST_IDLE;
              idx_d   = 8'd0;
              done_d  = 1'b1;
            end else begin
              state_d = ST_DELAY;
              idx_d   = idx_inc;
              dcnt_d  = d_at_least_one(dly_q[int'(idx_nxt)*DW +: DW]);
            end
          end else begin
            wcnt_d = wcnt_q - WW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = 8'd0;
          trig_d  = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 8'd0;
      last_q  <= 8'd0;
      dcnt_q  <= '0;
      wcnt_q  <= '0;
      dly_q   <= '0;
      wid_q   <= '0;
      trig_q  <= 1'b0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      dcnt_q  <= dcnt_d;
      wcnt_q  <= wcnt_d;
      dly_q   <= dly_d;
      wid_q   <= wid_d;
      trig_q  <= trig_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign O_trigger       = trig_q;
  assign O_trigger_pulse = pulse_q;
  assign O_pulse_index   = idx_q;
  assign O_busy          = busy_q;
  assign O_done          = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pw_trigger_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pw_trigger_seq
// Description : Self-checking bench for pw_trigger_seq. A reference model
//               derives the expected per-cycle waveform from the pulse
//               schedule (rise/fall times) of each configured sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pw_trigger_seq;

  localparam int NP   = 4;
  localparam int DW   = 20;
  localparam int WW   = 17;
  localparam int MAXC = 256;

  logic             fe_clk;
  logic             reset_n;
  logic             I_arm;
  logic             I_match;
  logic [7:0]       I_num_pulses;
  logic [NP*DW-1:0] I_delays;
  logic [NP*WW-1:0] I_widths;
  logic             O_trigger;
  logic             O_trigger_pulse;
  logic [7:0]       O_pulse_index;
  logic             O_busy;
  logic             O_done;

  pw_trigger_seq #(
    .pNUM_PULSES (NP),
    .pDELAY_WIDTH(DW),
    .pWIDTH_WIDTH(WW)
  ) dut (
    .fe_clk         (fe_clk),
    .reset_n        (reset_n),
    .I_arm          (I_arm),
    .I_match        (I_match),
    .I_num_pulses   (I_num_pulses),
    .I_delays       (I_delays),
    .I_widths       (I_widths),
    .O_trigger      (O_trigger),
    .O_trigger_pulse(O_trigger_pulse),
    .O_pulse_index  (O_pulse_index),
    .O_busy         (O_busy),
    .O_done         (O_done)
  );

  initial fe_clk = 1'b0;
  always #5 fe_clk = ~fe_clk;

  int total = 0;
  int bad   = 0;

  // Scenario configuration
  int cfg_n;
  int cfg_d [NP];
  int cfg_w [NP];
  int abort_c, extra_c, rewrite_c;
  bit want_extra, want_dm;

  // Expected waveform
  logic exp_trig  [MAXC];
  logic exp_pulse [MAXC];
  logic exp_busy  [MAXC];
  logic exp_done  [MAXC];
  int   exp_idx   [MAXC];
  int   model_end, busy_last;

  task automatic chk(input string tag, input int c, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, c, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int c, input int t, input int p,
                         input int i, input int b, input int d);
    chk({tag, ".trig"},  c, int'(O_trigger),       t);
    chk({tag, ".pulse"}, c, int'(O_trigger_pulse), p);
    chk({tag, ".idx"},   c, int'(O_pulse_index),   i);
    chk({tag, ".busy"},  c, int'(O_busy),          b);
    chk({tag, ".done"},  c, int'(O_done),          d);
  endtask

  // Schedule-based model: pulse k rises after its delay (min 1 for k>0),
  // stays high max(w,1) cycles; done follows the last fall.
  task automatic build_model();
    int n, rise, fall, dk, wk, start;
    for (int c = 0; c < MAXC; c++) begin
      exp_trig[c] = 0; exp_pulse[c] = 0; exp_busy[c] = 0; exp_done[c] = 0; exp_idx[c] = 0;
    end
    n = (cfg_n > NP) ? NP : cfg_n;
    model_end = 0;
    fall = 0;
    for (int k = 0; k < n; k++) begin
      dk = cfg_d[k];
      if (k > 0 && dk == 0) dk = 1;
      wk = (cfg_w[k] == 0) ? 1 : cfg_w[k];
      start = (k == 0) ? 1 : fall;
      rise  = (k == 0) ? 1 + dk : fall + dk;
      for (int c = start; c < rise + wk && c < MAXC; c++) begin
        exp_busy[c] = 1;
        exp_idx[c]  = k;
      end
      for (int c = rise; c < rise + wk && c < MAXC; c++) exp_trig[c] = 1;
      if (rise < MAXC) exp_pulse[rise] = 1;
      fall = rise + wk;
    end
    if (n > 0) begin
      model_end = fall;
      if (fall < MAXC) exp_done[fall] = 1;
    end
    if (abort_c >= 0) begin
      for (int c = abort_c + 1; c < MAXC; c++) begin
        exp_trig[c] = 0; exp_pulse[c] = 0; exp_busy[c] = 0; exp_done[c] = 0; exp_idx[c] = 0;
      end
    end
    busy_last = 0;
    for (int c = 0; c < MAXC; c++) if (exp_busy[c]) busy_last = c;
  endtask

  task automatic load_cfg_inputs();
    I_num_pulses = 8'(cfg_n);
    for (int k = 0; k < NP; k++) begin
      I_delays[k*DW +: DW] = DW'(cfg_d[k]);
      I_widths[k*WW +: WW] = WW'(cfg_w[k]);
    end
  endtask

  // Entered and left #1 after a rising edge; cycle 0 carries the match.
  task automatic run_seq(input string tag);
    int len, dm_c;
    build_model();
    if (want_extra) extra_c = (busy_last >= 1) ? int'($urandom_range(1, busy_last)) : -1;
    dm_c = (want_dm && model_end > 0) ? model_end : -1;
    len = model_end;
    if (abort_c > len) len = abort_c;
    if (extra_c > len) len = extra_c;
    if (rewrite_c > len) len = rewrite_c;
    len = len + 4;
    if (len > MAXC) len = MAXC;
    for (int c = 0; c < len; c++) begin
      chk_all(tag, c, int'(exp_trig[c]), int'(exp_pulse[c]), exp_idx[c],
              int'(exp_busy[c]), int'(exp_done[c]));
      if (c == 0) load_cfg_inputs();
      if (c == rewrite_c) begin
        I_num_pulses = 8'($urandom_range(0, 255));
        for (int k = 0; k < NP; k++) begin
          I_delays[k*DW +: DW] = DW'($urandom);
          I_widths[k*WW +: WW] = WW'($urandom);
        end
      end
      I_match = (c == 0) || (c == extra_c) || (c == dm_c);
      I_arm   = !(abort_c >= 0 && c >= abort_c);
      @(posedge fe_clk); #1;
    end
    I_match = 1'b0;
    I_arm   = 1'b1;
  endtask

  task automatic clear_opts();
    abort_c = -1; extra_c = -1; rewrite_c = -1;
    want_extra = 0; want_dm = 0;
    for (int k = 0; k < NP; k++) begin cfg_d[k] = 0; cfg_w[k] = 0; end
  endtask

  initial begin
    reset_n = 1'b0; I_arm = 1'b1; I_match = 1'b0;
    I_num_pulses = 8'd0; I_delays = '0; I_widths = '0;
    repeat (3) @(posedge fe_clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    @(posedge fe_clk); #1;
    chk_all("post_reset", 1, 0, 0, 0, 0, 0);

    // Single pulse, zero delay, match on the done cycle ignored
    clear_opts(); cfg_n = 1; cfg_w[0] = 1; want_dm = 1;
    run_seq("t1");

    // Three pulses with mixed delays/widths
    clear_opts(); cfg_n = 3;
    cfg_d[0] = 5; cfg_d[1] = 2; cfg_d[2] = 0;
    cfg_w[0] = 3; cfg_w[1] = 1; cfg_w[2] = 4;
    run_seq("t2");

    // Same sequence with a second match and config rewrite mid-run
    extra_c = 7; rewrite_c = 3;
    run_seq("t3");

    // Abort by I_arm low, then restart from pulse 0
    clear_opts(); cfg_n = 2;
    cfg_d[0] = 10; cfg_w[0] = 100; cfg_d[1] = 3; cfg_w[1] = 2;
    abort_c = 50;
    run_seq("t4a");
    abort_c = -1; cfg_d[0] = 2; cfg_w[0] = 3;
    run_seq("t4b");

    // Disabled and clamped pulse counts
    clear_opts(); cfg_n = 0; cfg_d[0] = 1; cfg_w[0] = 2;
    run_seq("t6a");
    clear_opts(); cfg_n = 9;
    for (int k = 0; k < NP; k++) begin cfg_d[k] = k; cfg_w[k] = k + 1; end
    run_seq("t6b");

    // Asynchronous reset while a pulse is high
    clear_opts(); cfg_n = 3;
    cfg_d[0] = 5; cfg_d[1] = 2; cfg_d[2] = 0;
    cfg_w[0] = 3; cfg_w[1] = 1; cfg_w[2] = 4;
    load_cfg_inputs();
    I_match = 1'b1;
    @(posedge fe_clk); #1;
    I_match = 1'b0;
    repeat (6) @(posedge fe_clk);
    #1;
    chk("t5.pre_trig", 7, int'(O_trigger), 1);
    #2 reset_n = 1'b0;
    #1;
    chk_all("t5.async", 7, 0, 0, 0, 0, 0);
    @(posedge fe_clk); #1;
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge fe_clk); #1;
      chk_all("t5.idle", c, 0, 0, 0, 0, 0);
    end

    // Randomized sequences
    for (int r = 0; r < 24; r++) begin
      clear_opts();
      cfg_n = int'($urandom_range(0, 9));
      for (int k = 0; k < NP; k++) begin
        cfg_d[k] = int'($urandom_range(0, 6));
        cfg_w[k] = int'($urandom_range(0, 5));
      end
      if ($urandom_range(0, 3) == 0) abort_c = int'($urandom_range(1, 30));
      want_extra = ($urandom_range(0, 1) == 1);
      want_dm    = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) rewrite_c = int'($urandom_range(1, 20));
      run_seq("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
